// File: rtl/hist_pkg.sv
// Shared types and constants for the frame histogram stage.
// Sample/increment widths, FSM states and bin bound record.
package hist_pkg;

  localparam int SAMPLE_W = 8;
  localparam int INC_W    = 3;

  typedef enum logic [1:0] {
    WAIT,
    SCAN,
    DRAIN
  } hist_state_e;

  typedef struct packed {
    logic [SAMPLE_W-1:0] lo;
    logic [SAMPLE_W-1:0] hi;
  } bin_bound_t;

  localparam bin_bound_t BND_RST = '{lo: 8'h00, hi: 8'hFF};

  function automatic logic in_rng(
    input logic [SAMPLE_W-1:0] o,
    input logic [SAMPLE_W-1:0] lo,
    input logic [SAMPLE_W-1:0] hi
  );
    return (o >= lo) && (o <= hi);
  endfunction

endpackage

// File: rtl/hist_bin_count.sv
// Counts how many of four observations fall in [lo, hi].
// An empty range (lo > hi) simply never matches.
module hist_bin_count
  import hist_pkg::*;
(
  input  logic [SAMPLE_W-1:0] o1_i,
  input  logic [SAMPLE_W-1:0] o2_i,
  input  logic [SAMPLE_W-1:0] o3_i,
  input  logic [SAMPLE_W-1:0] o4_i,
  input  logic [SAMPLE_W-1:0] lo_i,
  input  logic [SAMPLE_W-1:0] hi_i,
  output logic [INC_W-1:0]    cnt_o
);

  logic [3:0] hit;

  always_comb begin
    hit[0] = in_rng(o1_i, lo_i, hi_i);
    hit[1] = in_rng(o2_i, lo_i, hi_i);
    hit[2] = in_rng(o3_i, lo_i, hi_i);
    hit[3] = in_rng(o4_i, lo_i, hi_i);
    cnt_o  = INC_W'(hit[0]) + INC_W'(hit[1])
           + INC_W'(hit[2]) + INC_W'(hit[3]);
  end

endmodule

// File: rtl/hist_frame_accum.sv
// Frame histogram: scans one bin per cycle, drains counts at frame end.
// Define HIST_SAT_EN for saturating counters with sticky sat flag.
module hist_frame_accum
  import hist_pkg::*;
#(
  parameter int NUM_BINS     = 4,
  parameter int FRAME_GROUPS = 16,
  parameter int CNT_W        = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [SAMPLE_W-1:0]         o1,
  input  logic [SAMPLE_W-1:0]         o2,
  input  logic [SAMPLE_W-1:0]         o3,
  input  logic [SAMPLE_W-1:0]         o4,
  input  logic                        cfg_we,
  input  logic [$clog2(NUM_BINS)-1:0] cfg_idx,
  input  logic [SAMPLE_W-1:0]         cfg_lo,
  input  logic [SAMPLE_W-1:0]         cfg_hi,
  output logic                        rd_valid,
  input  logic                        rd_ready,
  output logic [$clog2(NUM_BINS)-1:0] rd_bin,
  output logic [CNT_W-1:0]            rd_count,
  output logic                        rd_last,
  output logic                        sat
);

  localparam int IDX_W = $clog2(NUM_BINS);
  localparam int GRP_W = $clog2(FRAME_GROUPS + 1);
  localparam logic [IDX_W-1:0] LAST_BIN = IDX_W'(NUM_BINS - 1);
  localparam logic [GRP_W-1:0] GRP_END  = GRP_W'(FRAME_GROUPS);

  hist_state_e         state_q, state_d;
  logic [IDX_W-1:0]    scan_q, scan_d;
  logic [GRP_W-1:0]    grp_q, grp_d;
  logic [IDX_W-1:0]    rdbin_q, rdbin_d;
  logic                sat_q, sat_d;
  logic [CNT_W-1:0]    cnt_q [NUM_BINS];
  logic [CNT_W-1:0]    cnt_d [NUM_BINS];
  bin_bound_t          bnd_q [NUM_BINS];
  bin_bound_t          bnd_d [NUM_BINS];
  logic [SAMPLE_W-1:0] obs_q [4];
  logic [SAMPLE_W-1:0] obs_d [4];

  bin_bound_t          cur_bnd;
  logic [INC_W-1:0]    inc;
`ifdef HIST_SAT_EN
  logic [CNT_W:0]      sum;
`endif

  // One shared comparator bank, steered by the scan index.
  assign cur_bnd = bnd_q[scan_q];

  hist_bin_count u_cnt (
    .o1_i  (obs_q[0]),
    .o2_i  (obs_q[1]),
    .o3_i  (obs_q[2]),
    .o4_i  (obs_q[3]),
    .lo_i  (cur_bnd.lo),
    .hi_i  (cur_bnd.hi),
    .cnt_o (inc)
  );

  always_comb begin
    state_d = state_q;
    scan_d  = scan_q;
    grp_d   = grp_q;
    rdbin_d = rdbin_q;
    sat_d   = sat_q;
    cnt_d   = cnt_q;
    bnd_d   = bnd_q;
    obs_d   = obs_q;
`ifdef HIST_SAT_EN
    sum     = '0;
`endif
    unique case (state_q)
      WAIT: begin
        if (cfg_we && grp_q == '0) begin
          bnd_d[cfg_idx] = '{lo: cfg_lo, hi: cfg_hi};
        end
        if (in_valid) begin
          obs_d[0] = o1;
          obs_d[1] = o2;
          obs_d[2] = o3;
          obs_d[3] = o4;
          scan_d   = '0;
          state_d  = SCAN;
        end
      end
      SCAN: begin
`ifdef HIST_SAT_EN
        sum = {1'b0, cnt_q[scan_q]} + (CNT_W + 1)'(inc);
        if (sum[CNT_W]) begin
          cnt_d[scan_q] = '1;
          sat_d         = 1'b1;
        end else begin
          cnt_d[scan_q] = sum[CNT_W-1:0];
        end
`else
        cnt_d[scan_q] = cnt_q[scan_q] + CNT_W'(inc);
`endif
        scan_d = scan_q + IDX_W'(1);
        if (scan_q == LAST_BIN) begin
          scan_d  = '0;
          grp_d   = grp_q + GRP_W'(1);
          state_d = (grp_d == GRP_END) ? DRAIN : WAIT;
        end
      end
      DRAIN: begin
        if (rd_ready) begin
          rdbin_d = rdbin_q + IDX_W'(1);
          if (rdbin_q == LAST_BIN) begin
            rdbin_d = '0;
            grp_d   = '0;
            sat_d   = 1'b0;
            state_d = WAIT;
            for (int i = 0; i < NUM_BINS; i++) begin
              cnt_d[i] = '0;
            end
          end
        end
      end
      default: state_d = WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT;
      scan_q  <= '0;
      grp_q   <= '0;
      rdbin_q <= '0;
      sat_q   <= 1'b0;
      for (int i = 0; i < NUM_BINS; i++) begin
        cnt_q[i] <= '0;
        bnd_q[i] <= BND_RST;
      end
      for (int i = 0; i < 4; i++) begin
        obs_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      scan_q  <= scan_d;
      grp_q   <= grp_d;
      rdbin_q <= rdbin_d;
      sat_q   <= sat_d;
      cnt_q   <= cnt_d;
      bnd_q   <= bnd_d;
      obs_q   <= obs_d;
    end
  end

  assign in_ready = (state_q == WAIT) && !rst;
  assign rd_valid = (state_q == DRAIN);
  assign rd_bin   = rdbin_q;
  assign rd_count = rd_valid ? cnt_q[rdbin_q] : '0;
  assign rd_last  = rd_valid && (rdbin_q == LAST_BIN);
  assign sat      = sat_q;

endmodule

// File: tb/tb_hist_frame_accum.sv
// Bench: wide (CNT_W=8) and narrow (CNT_W=3) instances share stimulus.
// Expected counts come from a per-frame range-count model.
module tb_hist_frame_accum;

  localparam int NB = 2;
  localparam int FG = 2;
`ifdef HIST_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic       clk, rst, in_valid, cfg_we, rd_ready;
  logic [7:0] o1, o2, o3, o4, cfg_lo, cfg_hi;
  logic [0:0] cfg_idx;

  logic       ir_a, rv_a, rl_a, sat_a;
  logic [0:0] rb_a;
  logic [7:0] rc_a;
  logic       ir_b, rv_b, rl_b, sat_b;
  logic [0:0] rb_b;
  logic [2:0] rc_b;

  int total, bad;
  int lo_m[NB], hi_m[NB], raw[NB], mgrp;

  hist_frame_accum #(.NUM_BINS(NB), .FRAME_GROUPS(FG), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_a),
    .o1(o1), .o2(o2), .o3(o3), .o4(o4),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_lo(cfg_lo), .cfg_hi(cfg_hi),
    .rd_valid(rv_a), .rd_ready(rd_ready), .rd_bin(rb_a),
    .rd_count(rc_a), .rd_last(rl_a), .sat(sat_a)
  );

  hist_frame_accum #(.NUM_BINS(NB), .FRAME_GROUPS(FG), .CNT_W(3)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_b),
    .o1(o1), .o2(o2), .o3(o3), .o4(o4),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_lo(cfg_lo), .cfg_hi(cfg_hi),
    .rd_valid(rv_b), .rd_ready(rd_ready), .rd_bin(rb_b),
    .rd_count(rc_b), .rd_last(rl_b), .sat(sat_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog time limit");
    $fatal(1);
  end

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int exp_cnt(input int r, input int w);
    int mx = (1 << w) - 1;
    if (SAT_EN) return (r > mx) ? mx : r;
    return r & mx;
  endfunction

  function automatic int exp_sat(input int w);
    int mx = (1 << w) - 1;
    int s = 0;
    for (int k = 0; k < NB; k++) if (SAT_EN && raw[k] > mx) s = 1;
    return s;
  endfunction

  task automatic model_add(input int a, input int b, input int c, input int d);
    int obs[4];
    obs = '{a, b, c, d};
    for (int k = 0; k < NB; k++)
      for (int j = 0; j < 4; j++)
        if (lo_m[k] <= obs[j] && obs[j] <= hi_m[k]) raw[k]++;
    mgrp++;
  endtask

  task automatic wait_rise(input string tag, input bit use_rv);
    int n = 0;
    @(negedge clk);
    while ((use_rv ? rv_a : ir_a) != 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    check(tag, n, 2);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    cfg_we = 1'b0;
    mgrp = 0;
    for (int k = 0; k < NB; k++) begin
      raw[k] = 0; lo_m[k] = 0; hi_m[k] = 255;
    end
    @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", ir_a, 0);
    check("rst_rd_valid", rv_a, 0);
    check("rst_rd_bin", rb_a, 0);
    check("rst_rd_count", rc_a, 0);
    check("rst_rd_last", rl_a, 0);
    check("rst_sat", sat_b, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", ir_a, 1);
    check("post_rst_valid", rv_a, 0);
  endtask

  task automatic cfg_write(input int idx, input int lo, input int hi);
    cfg_we = 1'b1;
    cfg_idx = 1'(idx);
    cfg_lo = 8'(lo);
    cfg_hi = 8'(hi);
    if (mgrp == 0) begin lo_m[idx] = lo; hi_m[idx] = hi; end
    @(posedge clk);
    #1 cfg_we = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_group(input int a, input int b, input int c, input int d,
                            input bit do_cfg, input int ci, input int cl,
                            input int ch, input bit scan_cfg);
    check("accept_ready", ir_a, 1);
    if (do_cfg) begin
      cfg_we = 1'b1; cfg_idx = 1'(ci); cfg_lo = 8'(cl); cfg_hi = 8'(ch);
      if (mgrp == 0) begin lo_m[ci] = cl; hi_m[ci] = ch; end
    end
    o1 = 8'(a); o2 = 8'(b); o3 = 8'(c); o4 = 8'(d);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cfg_we = 1'b0;
    if (scan_cfg) begin
      cfg_we = 1'b1; cfg_idx = 1'b0; cfg_lo = 8'd200; cfg_hi = 8'd255;
    end
    model_add(a, b, c, d);
    if (mgrp < FG) wait_rise("busy_cycles", 1'b0);
    else wait_rise("valid_latency", 1'b1);
    cfg_we = 1'b0;
    check("narrow_ready_match", ir_b, ir_a);
  endtask

  task automatic drain(input int stall);
    check("drain_valid", rv_a, 1);
    check("drain_valid_b", rv_b, 1);
    if (stall > 0) begin
      rd_ready = 1'b0;
      for (int i = 0; i < stall; i++) begin
        @(posedge clk);
        @(negedge clk);
        check("stall_valid", rv_a, 1);
        check("stall_bin", rb_a, 0);
        check("stall_count", rc_a, exp_cnt(raw[0], 8));
      end
      rd_ready = 1'b1;
    end
    for (int b = 0; b < NB; b++) begin
      check("rd_bin", rb_a, b);
      check("rd_count", rc_a, exp_cnt(raw[b], 8));
      check("rd_last", rl_a, (b == NB - 1) ? 1 : 0);
      check("rd_count_b", rc_b, exp_cnt(raw[b], 3));
      check("sat_a", sat_a, exp_sat(8));
      check("sat_b", sat_b, exp_sat(3));
      @(posedge clk);
      @(negedge clk);
    end
    check("end_valid", rv_a, 0);
    check("end_ready", ir_a, 1);
    check("end_sat_b", sat_b, 0);
    mgrp = 0;
    for (int k = 0; k < NB; k++) raw[k] = 0;
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; in_valid = 1'b0; cfg_we = 1'b0; rd_ready = 1'b1;
    o1 = '0; o2 = '0; o3 = '0; o4 = '0;
    cfg_idx = '0; cfg_lo = '0; cfg_hi = '0;
    @(negedge clk);
    do_reset();

    // Basic frame
    cfg_write(0, 0, 3);
    cfg_write(1, 0, 9);
    send_group(0, 4, 1, 1, 0, 0, 0, 0, 0);
    send_group(1, 12, 3, 11, 0, 0, 0, 0, 0);
    drain(0);

    // Empty range lo > hi
    cfg_write(0, 10, 5);
    send_group(5, 10, 7, 7, 0, 0, 0, 0, 0);
    send_group(5, 10, 7, 7, 0, 0, 0, 0, 0);
    drain(0);

    // Overlapping full-range bins; narrow counter overflows
    cfg_write(0, 0, 255);
    cfg_write(1, 0, 255);
    send_group($urandom_range(0, 255), $urandom_range(0, 255),
               $urandom_range(0, 255), $urandom_range(0, 255), 0, 0, 0, 0, 0);
    send_group($urandom_range(0, 255), $urandom_range(0, 255),
               $urandom_range(0, 255), $urandom_range(0, 255), 0, 0, 0, 0, 0);
    drain(1);

    // Reset during scan of the second group
    cfg_write(0, 0, 3);
    cfg_write(1, 50, 60);
    send_group(1, 2, 3, 55, 0, 0, 0, 0, 0);
    o1 = 8'd1; o2 = 8'd2; o3 = 8'd3; o4 = 8'd4;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("scan_busy", ir_a, 0);
    do_reset();
    send_group(0, 0, 0, 0, 0, 0, 0, 0, 0);
    send_group(0, 0, 0, 0, 0, 0, 0, 0, 0);
    drain(0);

    // Config writes outside the idle window are dropped; stalled drain
    cfg_write(0, 0, 3);
    cfg_write(1, 0, 9);
    send_group(2, 201, 250, 8, 0, 0, 0, 0, 1);
    send_group(220, 3, 0, 9, 1, 0, 200, 255, 0);
    drain(3);

    // Randomised frames, cfg write coinciding with first accept
    for (int f = 0; f < 8; f++) begin
      cfg_write(0, $urandom_range(0, 255), $urandom_range(0, 255));
      cfg_write(1, $urandom_range(0, 128), $urandom_range(64, 255));
      for (int g = 0; g < FG; g++) begin
        send_group($urandom_range(0, 255), $urandom_range(0, 255),
                   $urandom_range(0, 255), $urandom_range(0, 255),
                   1'($urandom_range(0, 1)), $urandom_range(0, 1),
                   $urandom_range(0, 255), $urandom_range(0, 255), 0);
      end
      drain($urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
